vx_issue_sched: RTL

VX_ISSUE_SCHED -- requirements
Module: VX_issue_sched

---
 rtl/vx_issue_sched.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/vx_issue_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vx_issue_sched                                               |
// | Description : Per-warp instruction buffers, pending-register scoreboard,   |
// |               round-robin warp selection and a single issue register.      |
// |               Optional macro ISSUE_SCHED_PERF_EN adds two 44-bit stall     |
// |               counters (scoreboard stalls, execute-unit stalls).           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vx_issue_sched #(
  parameter int NUM_WARPS  = 4,
  parameter int IBUF_DEPTH = 4,
  parameter int NUM_EX     = 4,
  parameter int DATAW      = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  // decode side
  input  logic                         dec_valid,
  output logic                         dec_ready,
  input  logic [$clog2(NUM_WARPS)-1:0] dec_wid,
  input  logic [$clog2(NUM_EX)-1:0]    dec_ex,
  input  logic                         dec_wb,
  input  logic [4:0]                   dec_rd,
  input  logic [4:0]                   dec_rs1,
  input  logic [4:0]                   dec_rs2,
  input  logic [4:0]                   dec_rs3,
  input  logic [DATAW-1:0]             dec_data,
  // issue side
  output logic                         iss_valid,
  input  logic [NUM_EX-1:0]            ex_ready,
  output logic [$clog2(NUM_WARPS)-1:0] iss_wid,
  output logic [$clog2(NUM_EX)-1:0]    iss_ex,
  output logic                         iss_wb,
  output logic [4:0]                   iss_rd,
  output logic [DATAW-1:0]             iss_data,
  // writeback release
  input  logic                         wb_valid,
  input  logic [$clog2(NUM_WARPS)-1:0] wb_wid,
  input  logic [4:0]                   wb_rd,
  input  logic                         wb_eop
`ifdef ISSUE_SCHED_PERF_EN
  ,
  output logic [43:0]                  perf_scb_stalls,
  output logic [43:0]                  perf_ex_stalls
`endif
);

  localparam int c_WID_W = $clog2(NUM_WARPS);
  localparam int c_EX_W  = $clog2(NUM_EX);
  localparam int c_PTR_W = $clog2(IBUF_DEPTH);

  typedef struct packed {
    logic [c_EX_W-1:0] ex;
    logic              wb;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rs3;
    logic [DATAW-1:0]  data;
  } entry_t;

  entry_t               w_dec_ent;
  entry_t               w_head [NUM_WARPS];
  logic [NUM_WARPS-1:0] w_empty;
  logic [NUM_WARPS-1:0] w_full;
  logic [NUM_WARPS-1:0] w_elig;
  logic [c_WID_W-1:0]   r_rr_ptr;
  logic [c_WID_W-1:0]   w_idx;
  logic [c_WID_W-1:0]   w_sel_wid;
  logic                 w_sel_any;
  logic                 w_fire;
  logic                 w_load;
  logic                 w_wb_clr;

  logic                 r_iss_valid;
  logic [c_WID_W-1:0]   r_iss_wid;
  logic [c_EX_W-1:0]    r_iss_ex;
  logic                 r_iss_wb;
  logic [4:0]           r_iss_rd;
  logic [DATAW-1:0]     r_iss_data;

  assign w_dec_ent = {dec_ex, dec_wb, dec_rd, dec_rs1, dec_rs2, dec_rs3, dec_data};
  // Full is the registered state: a same-cycle pop never frees a slot early.
  assign dec_ready = !w_full[dec_wid];
  assign w_fire    = r_iss_valid && ex_ready[r_iss_ex];
  assign w_load    = w_sel_any && (!r_iss_valid || w_fire);
  assign w_wb_clr  = wb_valid && wb_eop;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
    logic [c_PTR_W:0] r_wptr;
    logic [c_PTR_W:0] r_rptr;
    logic [31:0]      r_pend;
    entry_t           r_mem [IBUF_DEPTH];
    logic             w_enq;
    logic             w_pop;
    logic             w_hazard;

    assign w_enq      = dec_valid && dec_ready && (dec_wid == c_WID_W'(g));
    assign w_pop      = w_load && (w_sel_wid == c_WID_W'(g));
    assign w_empty[g] = (r_wptr == r_rptr);
    assign w_full[g]  = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                        (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);
    assign w_head[g]  = r_mem[r_rptr[c_PTR_W-1:0]];
    // Hazard check reads only registered pending bits; a writeback in this
    // cycle takes effect for eligibility one cycle later.
    assign w_hazard   = r_pend[w_head[g].rs1] || r_pend[w_head[g].rs2] ||
                        r_pend[w_head[g].rs3] ||
                        (w_head[g].wb && r_pend[w_head[g].rd]);
    assign w_elig[g]  = !w_empty[g] && !w_hazard;

    // Queue read/write pointers with wrap bit.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_enq) r_wptr <= r_wptr + (c_PTR_W+1)'(1);
        if (w_pop) r_rptr <= r_rptr + (c_PTR_W+1)'(1);
      end
    end

    // Queue storage; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
      if (w_enq) r_mem[r_wptr[c_PTR_W-1:0]] <= w_dec_ent;
    end

    // Pending-register bits: cleared on end-of-packet writeback, set on issue.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_pend <= '0;
      end else begin
        if (w_wb_clr && (wb_wid == c_WID_W'(g))) r_pend[wb_rd] <= 1'b0;
        if (w_pop && w_head[g].wb && (w_head[g].rd != 5'd0))
          r_pend[w_head[g].rd] <= 1'b1;
      end
    end
  end

  // Round-robin search for the first eligible warp starting at r_rr_ptr.
  always_comb begin
    w_sel_any = 1'b0;
    w_sel_wid = '0;
    w_idx     = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_idx = r_rr_ptr + c_WID_W'(i);
      if (!w_sel_any && w_elig[w_idx]) begin
        w_sel_any = 1'b1;
        w_sel_wid = w_idx;
      end
    end
  end

  // Round-robin pointer moves past the warp that was just selected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_rr_ptr <= '0;
    else if (w_load) r_rr_ptr <= w_sel_wid + c_WID_W'(1);
  end

  // Single issue register: refilled when empty or firing, held while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_iss_valid <= 1'b0;
      r_iss_wid   <= '0;
      r_iss_ex    <= '0;
      r_iss_wb    <= 1'b0;
      r_iss_rd    <= '0;
      r_iss_data  <= '0;
    end else if (w_load) begin
      r_iss_valid <= 1'b1;
      r_iss_wid   <= w_sel_wid;
      r_iss_ex    <= w_head[w_sel_wid].ex;
      r_iss_wb    <= w_head[w_sel_wid].wb;
      r_iss_rd    <= w_head[w_sel_wid].rd;
      r_iss_data  <= w_head[w_sel_wid].data;
    end else if (w_fire) begin
      r_iss_valid <= 1'b0;
    end
  end

  assign iss_valid = r_iss_valid;
  assign iss_wid   = r_iss_wid;
  assign iss_ex    = r_iss_ex;
  assign iss_wb    = r_iss_wb;
  assign iss_rd    = r_iss_rd;
  assign iss_data  = r_iss_data;

`ifdef ISSUE_SCHED_PERF_EN
  logic [43:0] r_perf_scb;
  logic [43:0] r_perf_ex;

  // Stall counters: scoreboard-blocked slots and execute-unit back-pressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_scb <= '0;
      r_perf_ex  <= '0;
    end else begin
      if (!(&w_empty) && !(|w_elig) && (!r_iss_valid || w_fire))
        r_perf_scb <= r_perf_scb + 44'd1;
      if (r_iss_valid && !ex_ready[r_iss_ex])
        r_perf_ex <= r_perf_ex + 44'd1;
    end
  end

  assign perf_scb_stalls = r_perf_scb;
  assign perf_ex_stalls  = r_perf_ex;
`endif

endmodule
`default_nettype wire
